pkt_mem_mc: RTL and testbench

Multi-channel packet data memory for the Ethernet MAC, replacing the single-port-pair behavioural FIFO store. One byte-enabled write port and NUM_CH read requesters share one physical array, partitioned into equal per-channel regions. Read requests are arbitrated round-robin, and read data returns through a registered, latency-configurable pipeline tagged with channel ID. Sits between the tx/rx packet controllers and their per-channel FIFO pointer logic.

---
 rtl/pkt_mem_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/pkt_mem_mc.sv | 170 +++++++++++++++++
 tb/tb_pkt_mem_mc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_mem_pkg.sv
// Shared constants, types and helpers for the multi-channel packet memory.
package pkt_mem_pkg;

    localparam int unsigned BYTE_W  = 8;
    // Wide enough to name any of the up-to-16 channels.
    localparam int unsigned CH_ID_W = 4;

    typedef logic [CH_ID_W-1:0] ch_id_t;

    // Channel-select width; a single channel still gets one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of byte lanes in a data word.
    function automatic int unsigned byte_cnt(input int unsigned dw);
        return dw / BYTE_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts after the
// last winner and wraps, so index 0 wins first out of reset.
module rr_arbiter
    import pkt_mem_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = ch_width(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  gnt_d;
    logic          found;

    // Scan requesters in priority order starting one past the last winner.
    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (rst_n) begin
            for (int step = 1; step <= N; step++) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && req[k] && (k == (int'(ptr_q) + step) % N)) begin
                        found    = 1'b1;
                        gnt_d[k] = 1'b1;
                        ptr_d    = PW'(k);
                    end
                end
            end
        end
    end

    assign gnt = gnt_d;

    // Last-winner pointer moves only when something is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pkt_mem_mc.sv
// Multi-channel packet data memory: one byte-enabled write port, NUM_CH
// round-robin read requesters, write-first collision handling and a 1- or
// 2-stage registered read return tagged with the channel.
module pkt_mem_mc
    import pkt_mem_pkg::*;
#(
    parameter  int DWIDTH = 32,
    parameter  int AWIDTH = 10,
    parameter  int NUM_CH = 4,
    parameter  int RD_LAT = 1,
    localparam int CHW    = ch_width(NUM_CH),
    localparam int NB     = byte_cnt(DWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [CHW-1:0]           wr_ch,
    input  logic [AWIDTH-1:0]        wr_addr,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic [NB-1:0]            wr_be,
    output logic                     wr_err,
    input  logic [NUM_CH-1:0]        rd_req,
    input  logic [NUM_CH*AWIDTH-1:0] rd_addr,
    output logic [NUM_CH-1:0]        rd_gnt,
    output logic                     rd_valid,
    output logic [CHW-1:0]           rd_ch,
    output logic [DWIDTH-1:0]        rd_data
);

    localparam int DEPTH = NUM_CH * (2 ** AWIDTH);
    localparam int IW    = CHW + AWIDTH;

    typedef struct packed {
        logic              valid;
        logic [CHW-1:0]    ch;
        logic [DWIDTH-1:0] data;
    } rd_stage_t;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic              wr_ch_ok;
    logic              wr_do;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [CHW-1:0]    gnt_ch;
    logic [AWIDTH-1:0] gnt_addr;
    logic [DWIDTH-1:0] rd_word;
    logic [DWIDTH-1:0] rd_merged;
    rd_stage_t         s1_q;
    rd_stage_t         s1_d;
    logic              wr_err_q;

    // When NUM_CH fills the channel field every encoding is a real channel.
    generate
        if (NUM_CH == (1 << CHW)) begin : g_ch_full
            assign wr_ch_ok = 1'b1;
        end else begin : g_ch_part
            assign wr_ch_ok = (32'(wr_ch) < 32'(NUM_CH));
        end
    endgenerate

    assign wr_do  = rst_n & wr_en & wr_ch_ok;
    assign wr_idx = {wr_ch, wr_addr};

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    // Turn the one-hot grant into a channel number and pick its address slice.
    always_comb begin
        gnt_ch   = '0;
        gnt_addr = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_gnt[k]) begin
                gnt_ch   = CHW'(k);
                gnt_addr = rd_addr[k*AWIDTH +: AWIDTH];
            end
        end
    end

    assign rd_idx  = {gnt_ch, gnt_addr};
    assign rd_word = mem_q[rd_idx];

    // Write-first bypass: bytes being written this edge replace the old ones.
    always_comb begin
        rd_merged = rd_word;
        for (int b = 0; b < NB; b++) begin
            if (wr_do && wr_be[b] && (wr_idx == rd_idx)) begin
                rd_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Byte-lane writes into the shared array; the array itself is not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_do && wr_be[b]) begin
                mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Stage 1 loads on a grant; channel and data hold otherwise.
    always_comb begin
        s1_d       = s1_q;
        s1_d.valid = |rd_gnt;
        if (|rd_gnt) begin
            s1_d.ch   = gnt_ch;
            s1_d.data = rd_merged;
        end
    end

    // Stage 1 register; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
        end else begin
            s1_q <= s1_d;
        end
    end

    // Error flag covers exactly the write attempted on the previous edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en & ~wr_ch_ok;
        end
    end

    assign wr_err = wr_err_q;

    generate
        if (RD_LAT == 2) begin : g_lat2
            rd_stage_t s2_q;
            rd_stage_t s2_d;

            // Stage 2 copies stage 1 only when it carries a valid word.
            always_comb begin
                s2_d       = s2_q;
                s2_d.valid = s1_q.valid;
                if (s1_q.valid) begin
                    s2_d.ch   = s1_q.ch;
                    s2_d.data = s1_q.data;
                end
            end

            // Stage 2 register, cleared with stage 1 on reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_q <= '0;
                end else begin
                    s2_q <= s2_d;
                end
            end

            assign rd_valid = s2_q.valid;
            assign rd_ch    = s2_q.ch;
            assign rd_data  = s2_q.data;
        end else begin : g_lat1
            assign rd_valid = s1_q.valid;
            assign rd_ch    = s1_q.ch;
            assign rd_data  = s1_q.data;
        end
    endgenerate

endmodule

// File: tb/tb_pkt_mem_mc.sv
// Bench for pkt_mem_mc: two instances (4 channels / latency 1 and
// 3 channels / latency 2) share one stimulus stream and are each compared
// against a word-array memory model with a due-cycle queue of pending reads.
module tb_pkt_mem_mc;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RW = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [3:0]     wr_be;
    logic [3:0]     rd_req;
    logic [4*AW-1:0] rd_addr;

    logic           a_wr_err, a_rd_valid;
    logic [3:0]     a_rd_gnt;
    logic [1:0]     a_rd_ch;
    logic [DW-1:0]  a_rd_data;
    logic           b_wr_err, b_rd_valid;
    logic [2:0]     b_rd_gnt;
    logic [1:0]     b_rd_ch;
    logic [DW-1:0]  b_rd_data;

    pkt_mem_mc #(.DWIDTH(DW), .AWIDTH(AW), .NUM_CH(4), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .wr_err(a_wr_err), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_gnt(a_rd_gnt), .rd_valid(a_rd_valid),
        .rd_ch(a_rd_ch), .rd_data(a_rd_data)
    );

    pkt_mem_mc #(.DWIDTH(DW), .AWIDTH(AW), .NUM_CH(3), .RD_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .wr_err(b_wr_err), .rd_req(rd_req[2:0]),
        .rd_addr(rd_addr[3*AW-1:0]), .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid),
        .rd_ch(b_rd_ch), .rd_data(b_rd_data)
    );

    typedef struct {
        int            inst;
        int            due;
        int            ch;
        logic [DW-1:0] data;
    } rd_t;

    int            n_total = 0;
    int            n_pass  = 0;
    int            nch [2] = '{4, 3};
    int            lat [2] = '{1, 2};
    logic [DW-1:0] mm [2][4*RW];
    int            last_g [2];
    int            exp_g [2];
    logic          exp_v [2];
    logic          exp_err [2];
    int            hold_ch [2];
    logic [DW-1:0] hold_d [2];
    rd_t           pend [$];
    int            edge_n = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input int last, input int n, input logic [3:0] req);
        for (int i = 1; i <= n; i++) begin
            int c;
            c = (last + i) % n;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [63:0] onehot(input int g);
        return (g < 0) ? 64'd0 : (64'd1 << g);
    endfunction

    // One clock: check grants before the edge, update the model at the edge,
    // check registered outputs at the following negedge.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) exp_g[i] = rst_n ? rr_pick(last_g[i], nch[i], rd_req) : -1;
        chk("a_gnt", 64'(a_rd_gnt), onehot(exp_g[0]));
        chk("b_gnt", 64'(b_rd_gnt), onehot(exp_g[1]));
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int k = pend.size() - 1; k >= 0; k--) if (pend[k].inst == i) pend.delete(k);
                exp_err[i] = 1'b0;
                hold_ch[i] = 0;
                hold_d[i]  = '0;
                last_g[i]  = nch[i] - 1;
            end else begin
                exp_err[i] = wr_en && (int'(wr_ch) >= nch[i]);
                if (wr_en && int'(wr_ch) < nch[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_be[b]) mm[i][int'(wr_ch)*RW + int'(wr_addr)][8*b +: 8] = wr_data[8*b +: 8];
                end
                if (exp_g[i] >= 0) begin
                    rd_t r;
                    r.inst = i;
                    r.due  = edge_n + lat[i] - 1;
                    r.ch   = exp_g[i];
                    r.data = mm[i][exp_g[i]*RW + int'(rd_addr[exp_g[i]*AW +: AW])];
                    pend.push_back(r);
                    last_g[i] = exp_g[i];
                end
            end
            exp_v[i] = 1'b0;
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k].inst == i) begin
                    if (pend[k].due == edge_n) begin
                        exp_v[i]   = 1'b1;
                        hold_ch[i] = pend[k].ch;
                        hold_d[i]  = pend[k].data;
                        pend.delete(k);
                    end
                    break;
                end
            end
        end
        @(negedge clk);
        chk("a_wr_err",   64'(a_wr_err),   64'(exp_err[0]));
        chk("a_rd_valid", 64'(a_rd_valid), 64'(exp_v[0]));
        chk("a_rd_ch",    64'(a_rd_ch),    64'(hold_ch[0]));
        chk("a_rd_data",  64'(a_rd_data),  64'(hold_d[0]));
        chk("b_wr_err",   64'(b_wr_err),   64'(exp_err[1]));
        chk("b_rd_valid", 64'(b_rd_valid), 64'(exp_v[1]));
        chk("b_rd_ch",    64'(b_rd_ch),    64'(hold_ch[1]));
        chk("b_rd_data",  64'(b_rd_data),  64'(hold_d[1]));
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        wr_be  = 4'h0;
        rd_req = 4'h0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4*RW; j++) mm[i][j] = '0;
            last_g[i] = nch[i] - 1;
        end
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        wr_be = '0; rd_req = '0; rd_addr = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Fill every region so all later reads hit written words.
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < RW; a++) begin
                wr_en = 1'b1; wr_ch = 2'(c); wr_addr = AW'(a);
                wr_data = $urandom; wr_be = 4'hF;
                tick();
            end
        end
        idle();

        // Basic write then read on channel 1.
        wr_en = 1'b1; wr_ch = 2'd1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        tick();
        idle();
        rd_req = 4'b0010; rd_addr = {4{4'd5}};
        #1;
        chk("a_gnt_ch1", 64'(a_rd_gnt), 64'(4'b0010));
        chk("b_gnt_ch1", 64'(b_rd_gnt), 64'(3'b010));
        tick();
        idle();
        chk("a_dead_v",    64'(a_rd_valid), 64'd1);
        chk("a_dead_ch",   64'(a_rd_ch),    64'd1);
        chk("a_dead_data", 64'(a_rd_data),  64'(32'hDEADBEEF));
        tick();
        chk("b_dead_v",    64'(b_rd_valid), 64'd1);
        chk("b_dead_data", 64'(b_rd_data),  64'(32'hDEADBEEF));
        rd_req = 4'b0001;
        tick();
        idle();
        chk("a_ch0_untouched", 64'(a_rd_data), 64'(mm[0][5]));
        tick();
        tick();

        // Fresh round-robin burst with everyone requesting.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rd_req = 4'hF; rd_addr = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("a_burst_v",  64'(a_rd_valid), 64'd1);
            chk("a_burst_ch", 64'(a_rd_ch),    64'(k % 4));
        end
        idle();
        tick();
        tick();

        // Same-edge partial write and read of one address.
        wr_en = 1'b1; wr_ch = 2'd2; wr_addr = 4'd7; wr_data = 32'h11223344; wr_be = 4'hF;
        tick();
        wr_be = 4'h3; wr_data = 32'hAAAABBBB; rd_req = 4'b0100; rd_addr = 16'h0700;
        tick();
        rd_req = 4'h0; wr_be = 4'hF; wr_data = 32'h0;
        chk("a_collide", 64'(a_rd_data), 64'(32'h1122BBBB));
        tick();
        idle();
        chk("b_collide", 64'(b_rd_data), 64'(32'h1122BBBB));
        tick();

        // Write to channel 3: illegal for the 3-channel instance only.
        wr_en = 1'b1; wr_ch = 2'd3; wr_addr = 4'd9; wr_data = $urandom; wr_be = 4'hF;
        tick();
        idle();
        chk("b_err_pulse", 64'(b_wr_err), 64'd1);
        chk("a_err_none",  64'(a_wr_err), 64'd0);
        tick();
        chk("b_err_clear", 64'(b_wr_err), 64'd0);
        rd_req = 4'b0111; rd_addr = {4{4'd9}};
        for (int k = 0; k < 3; k++) tick();
        idle();
        tick();
        tick();

        // Reset lands while a latency-2 read is in flight.
        rd_req = 4'b0100; rd_addr = 16'($urandom);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        chk("b_rst_v",    64'(b_rd_valid), 64'd0);
        chk("b_rst_ch",   64'(b_rd_ch),    64'd0);
        chk("b_rst_data", 64'(b_rd_data),  64'd0);
        tick();
        chk("b_rst_v2",   64'(b_rd_valid), 64'd0);
        rst_n = 1'b1; rd_req = 4'hF;
        #1;
        chk("a_post_rst_gnt", 64'(a_rd_gnt), 64'(4'b0001));
        chk("b_post_rst_gnt", 64'(b_rd_gnt), 64'(3'b001));
        tick();
        idle();
        tick();
        tick();

        // Random traffic with occasional reset.
        for (int n = 0; n < 300; n++) begin
            rst_n   = ($urandom_range(0, 49) != 0);
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_ch   = 2'($urandom);
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            wr_be   = 4'($urandom);
            rd_req  = 4'($urandom);
            rd_addr = 16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
